// File: rtl/cpu_pkg.sv
// Shared types and constants for the decode/register-read stage:
// decoded instruction fields, register-file geometry and source-port indices.
package cpu_pkg;

  localparam int NREGS   = 32;
  localparam int ADDR_W  = $clog2(NREGS);
  localparam int DATA_W  = 64;

  localparam int NSRC    = 3;
  localparam int SRC_RS1 = 0;
  localparam int SRC_RS2 = 1;
  localparam int SRC_RS3 = 2;

  typedef struct packed {
    logic [6:0]  opCode;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [1:0]  set_type;
    logic [11:0] imm12;
    logic [6:0]  imm7;
    logic [4:0]  imm5;
    logic [4:0]  round;
  } instr_fields_t;

  // Maps a source-port index onto the matching register field.
  function automatic logic [ADDR_W-1:0] src_addr(input instr_fields_t f, input int idx);
    if (idx == SRC_RS1) return f.rs1;
    else if (idx == SRC_RS2) return f.rs2;
    else return f.rs3;
  endfunction

endpackage

// File: rtl/regfile_3r1w.sv
// Architectural register file: three combinational read ports, one clocked
// write port, x0 hardwired to zero, asynchronous active-low reset.
module regfile_3r1w #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 32,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [2:0][ADDR_W-1:0]      rd_addr,
  output logic [2:0][DATA_W-1:0]      rd_data
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rd
      assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 : regs_q[rd_addr[gi]];
    end
  endgenerate

endmodule

// File: rtl/reg_read_stage.sv
// Decode/register-read stage: reads up to three operands, tracks in-flight
// destinations in a scoreboard, stalls fetch on RAW/WAW hazards and holds a
// valid/ready output register toward execute. Define REG_READ_BYPASS_EN to
// let a same-cycle writeback resolve a hazard and supply the operand directly.
module reg_read_stage
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  instr_fields_t       in_fields,
  input  logic [NSRC-1:0]     in_src_used,
  input  logic                in_wr_rd,
  input  logic                flush,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output instr_fields_t       out_fields,
  output logic                out_wr_rd,
  output logic [DATA_W-1:0]   out_rs1_data,
  output logic [DATA_W-1:0]   out_rs2_data,
  output logic [DATA_W-1:0]   out_rs3_data
);

  logic [NREGS-1:0]             pending_q, pending_d;
  logic                         out_valid_q, out_valid_d;
  instr_fields_t                fields_q, fields_d;
  logic                         wr_rd_q, wr_rd_d;
  logic [NSRC-1:0][DATA_W-1:0]  opnd_q, opnd_d;

  logic [NSRC-1:0][ADDR_W-1:0]  src_addr_w;
  logic [NSRC-1:0][DATA_W-1:0]  rf_data;
  logic [NSRC-1:0][DATA_W-1:0]  src_data;
  logic [NSRC-1:0]              src_hazard;
  logic                         rd_writes;
  logic                         waw_hazard;
  logic                         hazard;
  logic                         accept;
  logic                         kill_writes;

  regfile_3r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wb_en),
    .wr_addr (wb_rd),
    .wr_data (wb_data),
    .rd_addr (src_addr_w),
    .rd_data (rf_data)
  );

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign src_addr_w[gi] = src_addr(in_fields, gi);
`ifdef REG_READ_BYPASS_EN
      logic wb_hit;
      assign wb_hit = wb_en && (wb_rd == src_addr_w[gi]) && (src_addr_w[gi] != '0);
      assign src_hazard[gi] = in_src_used[gi] && (src_addr_w[gi] != '0)
                              && pending_q[src_addr_w[gi]] && !wb_hit;
      assign src_data[gi] = !in_src_used[gi] ? '0 : (wb_hit ? wb_data : rf_data[gi]);
`else
      assign src_hazard[gi] = in_src_used[gi] && (src_addr_w[gi] != '0)
                              && pending_q[src_addr_w[gi]];
      assign src_data[gi] = in_src_used[gi] ? rf_data[gi] : '0;
`endif
    end
  endgenerate

  assign rd_writes = in_wr_rd && (in_fields.rd != '0);

`ifdef REG_READ_BYPASS_EN
  assign waw_hazard = rd_writes && pending_q[in_fields.rd]
                      && !(wb_en && (wb_rd == in_fields.rd));
`else
  assign waw_hazard = rd_writes && pending_q[in_fields.rd];
`endif

  assign hazard   = (|src_hazard) || waw_hazard;
  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // WAW stalling keeps one writer per register, so a killed writer owns its bit.
  assign kill_writes = flush && out_valid_q && wr_rd_q && (fields_q.rd != '0);

  always_comb begin
    pending_d = pending_q;
    if (wb_en) pending_d[wb_rd] = 1'b0;
    if (kill_writes) pending_d[fields_q.rd] = 1'b0;
    if (accept && rd_writes) pending_d[in_fields.rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    fields_d    = fields_q;
    wr_rd_d     = wr_rd_q;
    opnd_d      = opnd_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      fields_d    = in_fields;
      wr_rd_d     = in_wr_rd;
      opnd_d      = src_data;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      fields_q    <= '0;
      wr_rd_q     <= 1'b0;
      opnd_q      <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      fields_q    <= fields_d;
      wr_rd_q     <= wr_rd_d;
      opnd_q      <= opnd_d;
    end
  end

  assign out_valid    = out_valid_q && !flush;
  assign out_fields   = fields_q;
  assign out_wr_rd    = wr_rd_q;
  assign out_rs1_data = opnd_q[SRC_RS1];
  assign out_rs2_data = opnd_q[SRC_RS2];
  assign out_rs3_data = opnd_q[SRC_RS3];

endmodule

// File: doc/reg_read_stage.md
Name: reg_read_stage

Overview:
- Decode/register-read stage directly downstream of the fetch stage.
- Takes the decoded instruction fields (opCode, rs1/rs2/rs3, rd, funct7, funct3, set_type, imm12/7/5, round) and reads the 32-entry register file through three read ports, including rs3 for the crypto ops.
- Tracks in-flight destination registers with a scoreboard, stalls fetch on RAW/WAW hazards, and holds a valid/ready pipeline register feeding execute.

Parameters:
- DATA_W, 64, register/operand width.
- NREGS, 32, architectural register count; x0 reads zero and ignores writes.
- ADDR_W, 5, register index width, equal to $clog2(NREGS).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present from fetch.
- in_ready  out  1  stage accepts the instruction this cycle; low means stall PC.
- in_fields  in  instr_fields_t  packed decoded fields from fetch.
- in_src_used  in  3  bit0=rs1, bit1=rs2, bit2=rs3 are real sources.
- in_wr_rd  in  1  instruction writes rd.
- flush  in  1  branchTaken from execute; kills younger instructions.
- wb_en  in  1  writeback strobe.
- wb_rd  in  ADDR_W  writeback register.
- wb_data  in  DATA_W  writeback value.
- out_valid  out  1  execute-side valid.
- out_ready  in  1  execute accepts.
- out_fields  out  instr_fields_t  registered fields.
- out_wr_rd  out  1  registered write flag.
- out_rs1_data, out_rs2_data, out_rs3_data  out  DATA_W each  operands, forced to 0 when the source is unused.

Behaviour:
- Reset (async, active-low): all registers 0, scoreboard 0, out_valid 0, all out_* 0. The clk/reset interface is fixed: one clock, asynchronous active-low reset.
- Register file write: wb_en && wb_rd!=0 writes wb_data at the clock edge. x0 always reads 0.
- Scoreboard: pending[NREGS]. A bit is set when an instruction is accepted with in_wr_rd && rd!=0. A bit is cleared on wb_en for wb_rd.
- Same-cycle set and clear on one register: set wins.
- Hazard, for each used source s with s!=0: stall if pending[s], unless bypassed (see Optional Feature). WAW: stall if in_wr_rd && rd!=0 && pending[rd], same bypass rule.
- in_ready = (!out_valid_q || out_ready) && !hazard && !flush.
- Accept (in_valid && in_ready): operands, fields and wr_rd are registered into the output register and out_valid_q is set, so latency is 1 cycle.
- Drain (out_valid_q && out_ready && no accept): out_valid_q is cleared.
- out_valid = out_valid_q && !flush.
- Flush: the incoming instruction is dropped and out_valid_q is cleared. If the killed output instruction had wr_rd && rd!=0, its pending bit is cleared. This is exact because WAW stalling guarantees one writer per register.
- Flush and wb_en in the same cycle: both are applied.
- Reset mid-operation: the entire state returns to reset values immediately.
- Output register holds stable while out_valid && !out_ready.

Optional Feature:
- Macro: REG_READ_BYPASS_EN.
- Enabled: a source or rd equal to wb_rd with wb_en this cycle is not a hazard, and the operand takes wb_data combinationally.
- Disabled: a pending bit clearing this cycle still stalls. The read happens the following cycle from the register file, giving a +1 cycle RAW penalty.
- Pending-bit semantics are otherwise identical.

Decomposition:
- Package cpu_pkg holds:
  - instr_fields_t: opCode[6:0], funct7[6:0], rs1/rs2/rs3/rd[4:0], funct3[2:0], set_type[1:0], imm12[11:0], imm7[6:0], imm5[4:0], round[4:0].
  - NREGS, ADDR_W, DATA_W, SRC_RS1/RS2/RS3 bit indices.
- Sub-module regfile_3r1w: 3 async read ports, 1 sync write port, x0 hardwired to 0, async active-low reset. Hazard and scoreboard logic stay in the top module.

Test Plan:
1. Reset, then wb x5=0x1234. Issue rs1=5, src_used=001 → next cycle out_valid=1, out_rs1_data=0x1234, out_rs2/3_data=0.
2. Issue A (rd=7, wr_rd=1), then B (rs2=7) → B stalls, in_ready=0. Apply wb x7=0xAB → bypass build: B accepted that cycle with rs2_data=0xAB; non-bypass build: B accepted one cycle later with 0xAB.
3. out_ready=0 with out_valid=1 for 3 cycles → outputs stable, in_ready=0. out_ready=1 → next instruction accepted the same cycle.
4. Output holds rd=9 pending and flush=1 → out_valid=0 that cycle, pending[9]=0 next cycle, incoming instruction dropped.
5. Issue rd=0 with wr_rd=1, then rs1=0 → no stall, rs1_data=0. wb to x0 with 0xFF → x0 still reads 0.
6. Three-source crypto op rs1=1, rs2=2, rs3=3 with x3 pending → stall until wb x3; all three operands correct on acceptance.
